// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode encoding (unchanged from
// the combinational ALU) and the control FSM state type.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_ROR = 4'b0010;
    localparam logic [3:0] OP_ROL = 4'b0011;
    localparam logic [3:0] OP_SHR = 4'b0100;
    localparam logic [3:0] OP_SHL = 4'b0101;
    localparam logic [3:0] OP_AND = 4'b0110;
    localparam logic [3:0] OP_OR  = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_DIV = 4'b1001;
    localparam logic [3:0] OP_NEG = 4'b1010;
    localparam logic [3:0] OP_NOT = 4'b1011;

    // Control FSM states; explicit encoding so the state register can be
    // probed as a plain 2-bit value.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN_MUL = 2'd1,
        RUN_DIV = 2'd2,
        FIXUP   = 2'd3
    } alu_state_e;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative signed multiply (radix-2 Booth) and signed divide (restoring on
// magnitudes plus one sign-fixup cycle). Operands are captured on start.
// step_last marks the cycle whose edge performs the final iteration step;
// done marks the cycle whose edge should load res_lo/res_hi into the caller.
module alu_muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             start_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             step_last,
    output logic             done,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi
);

    localparam int CW = $clog2(WIDTH);

    // Booth product register: {hi (WIDTH+1), multiplier (WIDTH), q_-1}.
    // The hi part carries one extra sign bit so that subtracting the most
    // negative multiplicand cannot overflow.
    logic [2*WIDTH+1:0] prod_q, prod_d;
    logic [WIDTH:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic               q_neg_q, q_neg_d;
    logic               r_neg_q, r_neg_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               run_q, run_d;
    logic               div_q, div_d;
    logic               fix_q, fix_d;

    logic [WIDTH:0]     hi_sum;
    logic [WIDTH:0]     shifted;

    // Next-state for one Booth or restoring step, plus result selection.
    always_comb begin
        prod_d  = prod_q;
        mcand_d = mcand_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        cnt_d   = cnt_q;
        run_d   = run_q;
        div_d   = div_q;
        fix_d   = 1'b0;
        hi_sum  = prod_q[2*WIDTH+1:WIDTH+1];
        shifted = {rem_q, quo_q[WIDTH-1]};

        step_last = run_q && (cnt_q == CW'(WIDTH - 1));

        if (start) begin
            run_d   = 1'b1;
            div_d   = start_div;
            cnt_d   = '0;
            prod_d  = {{(WIDTH + 1){1'b0}}, b, 1'b0};
            mcand_d = {a[WIDTH-1], a};
            rem_d   = '0;
            quo_d   = a[WIDTH-1] ? (~a + 1'b1) : a;
            dvs_d   = b[WIDTH-1] ? (~b + 1'b1) : b;
            q_neg_d = a[WIDTH-1] ^ b[WIDTH-1];
            r_neg_d = a[WIDTH-1];
        end else if (run_q) begin
            cnt_d = cnt_q + 1'b1;
            if (!div_q) begin
                case (prod_q[1:0])
                    2'b01:   hi_sum = prod_q[2*WIDTH+1:WIDTH+1] + mcand_q;
                    2'b10:   hi_sum = prod_q[2*WIDTH+1:WIDTH+1] - mcand_q;
                    default: hi_sum = prod_q[2*WIDTH+1:WIDTH+1];
                endcase
                prod_d = {hi_sum[WIDTH], hi_sum, prod_q[WIDTH:1]};
            end else begin
                // Remainder stays below the divisor, so the WIDTH-bit
                // subtraction never loses information.
                if (shifted >= {1'b0, dvs_q}) begin
                    rem_d = shifted[WIDTH-1:0] - dvs_q;
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = shifted[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
            end
            if (step_last) begin
                run_d = 1'b0;
                fix_d = div_q;
            end
        end

        done = (step_last && !div_q) || fix_q;

        if (div_q) begin
            res_lo = q_neg_q ? (~quo_q + 1'b1) : quo_q;
            res_hi = r_neg_q ? (~rem_q + 1'b1) : rem_q;
        end else begin
            res_lo = prod_d[WIDTH:1];
            res_hi = prod_d[2*WIDTH:WIDTH+1];
        end
    end

    // Iteration state registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q  <= '0;
            mcand_q <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            cnt_q   <= '0;
            run_q   <= 1'b0;
            div_q   <= 1'b0;
            fix_q   <= 1'b0;
        end else begin
            prod_q  <= prod_d;
            mcand_q <= mcand_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
            div_q   <= div_d;
            fix_q   <= fix_d;
        end
    end

endmodule

// File: rtl/alu_seq_n.sv
// Clocked ALU with start/busy/done handshake.
// Handshake: a request is accepted on a rising edge where in_start = 1 and
// out_busy = 0; opcode and operands are captured on that edge. out_done
// pulses for exactly one cycle once results are loaded; results and the
// div-by-zero flag hold until the next out_done. Starts while busy are dropped.
module alu_seq_n
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             in_clk,
    input  logic             in_rst_n,
    input  logic             in_start,
    input  logic [3:0]       in_opcode,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_busy,
    output logic             out_done,
    output logic [WIDTH-1:0] out_result_lo,
    output logic [WIDTH-1:0] out_result_hi,
    output logic             out_div_by_zero
);

    localparam int SHW = $clog2(WIDTH);

    alu_state_e       state_q, state_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             dbz_q, dbz_d;
    logic             done_q, done_d;

    logic [SHW-1:0]   sh_amt;
    logic [SHW:0]     sh_inv;
    logic [WIDTH-1:0] single_res;

    logic             iter_start;
    logic             iter_div;
    logic             iter_step_last;
    logic             iter_done;
    logic [WIDTH-1:0] iter_lo;
    logic [WIDTH-1:0] iter_hi;

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk       (in_clk),
        .rst_n     (in_rst_n),
        .start     (iter_start),
        .start_div (iter_div),
        .a         (in_a),
        .b         (in_b),
        .step_last (iter_step_last),
        .done      (iter_done),
        .res_lo    (iter_lo),
        .res_hi    (iter_hi)
    );

    // Single-cycle result from the live inputs; only used on the accept edge.
    // Rotates use (WIDTH - amount), which equals WIDTH for amount 0 and so
    // shifts the wrap-around term out entirely.
    always_comb begin
        sh_amt = in_b[SHW-1:0];
        sh_inv = (SHW + 1)'(WIDTH) - {1'b0, sh_amt};
        case (in_opcode)
            OP_ADD:  single_res = in_a + in_b;
            OP_SUB:  single_res = in_a - in_b;
            OP_ROR:  single_res = (in_a >> sh_amt) | (in_a << sh_inv);
            OP_ROL:  single_res = (in_a << sh_amt) | (in_a >> sh_inv);
            OP_SHR:  single_res = in_a >> sh_amt;
            OP_SHL:  single_res = in_a << sh_amt;
            OP_AND:  single_res = in_a & in_b;
            OP_OR:   single_res = in_a | in_b;
            OP_NEG:  single_res = ~in_a + 1'b1;
            OP_NOT:  single_res = ~in_a;
            default: single_res = '0;
        endcase
    end

    // Control FSM: accept, dispatch to the iterator, and load output registers.
    always_comb begin
        state_d    = state_q;
        lo_d       = lo_q;
        hi_d       = hi_q;
        dbz_d      = dbz_q;
        done_d     = 1'b0;
        iter_start = 1'b0;
        iter_div   = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_start) begin
                    if (in_opcode == OP_MUL) begin
                        state_d    = RUN_MUL;
                        iter_start = 1'b1;
                    end else if (in_opcode == OP_DIV && in_b != '0) begin
                        state_d    = RUN_DIV;
                        iter_start = 1'b1;
                        iter_div   = 1'b1;
                    end else if (in_opcode == OP_DIV) begin
                        lo_d   = '1;
                        hi_d   = in_a;
                        dbz_d  = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        lo_d   = single_res;
                        hi_d   = '0;
                        dbz_d  = 1'b0;
                        done_d = 1'b1;
                    end
                end
            end
            RUN_MUL: begin
                if (iter_done) begin
                    state_d = IDLE;
                    lo_d    = iter_lo;
                    hi_d    = iter_hi;
                    dbz_d   = 1'b0;
                    done_d  = 1'b1;
                end
            end
            RUN_DIV: begin
                if (iter_step_last) begin
                    state_d = FIXUP;
                end
            end
            FIXUP: begin
                state_d = IDLE;
                lo_d    = iter_lo;
                hi_d    = iter_hi;
                dbz_d   = 1'b0;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q <= IDLE;
            lo_q    <= '0;
            hi_q    <= '0;
            dbz_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            dbz_q   <= dbz_d;
            done_q  <= done_d;
        end
    end

    assign out_busy        = (state_q != IDLE);
    assign out_done        = done_q;
    assign out_result_lo   = lo_q;
    assign out_result_hi   = hi_q;
    assign out_div_by_zero = dbz_q;

endmodule

// File: doc/alu_seq_n.md
# alu_seq_n

Parametrised, clocked successor to the combinational 32-bit ALU. It keeps the same 4-bit opcode map and adds iterative signed MUL and DIV, which previously returned 0. MUL and DIV produce a double-width HI/LO result. A start/busy/done handshake lets the datapath control FSM issue one operation at a time and stall on long ops.

## Interface
- WIDTH, 32: operand/result width; must be ≥ 4 and a power of two.
- in_clk  input  1  system clock, rising edge.
- in_rst_n  input  1  asynchronous active-low reset.
- in_start  input  1  request; accepted on a rising edge when out_busy = 0.
- in_opcode  input  4  operation, captured at accept.
- in_a  input  WIDTH  operand A, captured at accept.
- in_b  input  WIDTH  operand B / shift amount / divisor, captured at accept.
- out_busy  output  1  high while a MUL/DIV iteration is in progress.
- out_done  output  1  one-cycle pulse; results valid from this cycle on.
- out_result_lo  output  WIDTH  result, product low half, or quotient.
- out_result_hi  output  WIDTH  product high half or remainder; 0 for all other ops.
- out_div_by_zero  output  1  set with out_done for DIV with B = 0; cleared at the next out_done.

## Operation
- Opcode map:
  - 0000 ADD
  - 0001 SUB (A−B)
  - 0010 ROR
  - 0011 ROL
  - 0100 SHR (logical)
  - 0101 SHL
  - 0110 AND
  - 0111 OR
  - 1000 MUL
  - 1001 DIV
  - 1010 NEG (−A)
  - 1011 NOT (~A)
  - 1100–1111 undefined: result 0, single-cycle.
- Arithmetic wraps modulo 2^WIDTH. There are no flags except div-by-zero.
- Shift and rotate amount is in_b[log2(WIDTH)-1:0]; upper bits are ignored. An amount of 0 passes A through.
- MUL:
  - Signed two's-complement radix-2 Booth, one step per cycle, WIDTH steps.
  - {hi, lo} = full 2·WIDTH-bit signed product.
- DIV:
  - Signed, truncating toward zero.
  - Restoring division on magnitudes, WIDTH steps, then one sign-fixup cycle.
  - lo = quotient; hi = remainder, with the sign of the dividend.
  - Most-negative ÷ −1: lo = most-negative, hi = 0 (wrap, no flag).
- Divide by zero: lo = all ones, hi = A, out_div_by_zero = 1. Completes as a single-cycle op; no iteration.
- FSM states:
  - IDLE → RUN_MUL (accepted MUL).
  - IDLE → RUN_DIV (accepted DIV, B ≠ 0).
  - RUN_MUL → IDLE after WIDTH steps.
  - RUN_DIV → FIXUP after WIDTH steps.
  - FIXUP → IDLE.
- All other ops stay in IDLE: results are loaded on the accept edge.
- A start while out_busy = 1 is ignored; it is not queued.
- Operands are captured at accept, so later input changes do not affect the result.
- Result and flag registers hold until the next out_done.

## Timing
- Reset (asynchronous, immediate):
  - FSM → IDLE.
  - out_busy = 0, out_done = 0, out_result_lo = 0, out_result_hi = 0, out_div_by_zero = 0.
  - An in-flight MUL/DIV is aborted with no done pulse.
- Let the accept edge be edge 0. out_done is high during the cycle after the edge that loads the results.
- Single-cycle ops (including div-by-zero and undefined opcodes):
  - Results load on edge 0; out_done is high for cycle 0→1.
  - Latency 1; out_busy never asserts.
- MUL:
  - out_busy is high from edge 0 to edge WIDTH.
  - Results load on edge WIDTH (steps run on edges 1..WIDTH); out_done is high for cycle WIDTH→WIDTH+1.
  - Latency WIDTH+1 (33 for WIDTH = 32).
- DIV:
  - out_busy is high from edge 0 to edge WIDTH+1.
  - Results load on edge WIDTH+1; out_done is high after it.
  - Latency WIDTH+2 (34 for WIDTH = 32).
- out_busy = 0 in the out_done cycle, so a start in that cycle is accepted on the next edge (back-to-back, no bubble).

## Structure
- Shared package alu_pkg:
  - opcode localparams (OP_ADD … OP_NOT), matching the existing encoding;
  - FSM state enum (IDLE, RUN_MUL, RUN_DIV, FIXUP).
- Sub-module alu_muldiv_iter:
  - contains the iteration counter, Booth accumulator, restoring remainder/quotient registers and sign fixup;
  - has a start/done interface to the top.
- The top holds the combinational single-cycle path, operand capture, FSM and output registers.

## Test plan
- ADD A = 0x0000FFFF, B = 0x00000001 → lo = 0x00010000, hi = 0; out_done one cycle after accept; out_busy never high.
- ROL A = 0x80000001, B = 0x00000021 (amount 1) → lo = 0x00000003; SUB A = 0x0000FFFF, B = 0x000000FF → lo = 0x0000FF00.
- MUL A = 0xFFFFFFFD (−3), B = 7 → hi = 0xFFFFFFFF, lo = 0xFFFFFFEB; out_done exactly 33 cycles after accept; a start at cycle 5 is ignored.
- DIV A = 0xFFFFFFF9 (−7), B = 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF, flag = 0; done at 34 cycles. Then DIV A = 5, B = 0 → lo = 0xFFFFFFFF, hi = 5, flag = 1; done at 1 cycle.
- Back-to-back: ADD issued in the MUL out_done cycle is accepted; its out_done follows one cycle later with the correct sum.
- in_rst_n low at cycle 10 of a MUL → all outputs 0 immediately, with no done pulse. After release, NEG A = 1 → lo = 0xFFFFFFFF.
